// File: rtl/ascon_128a_pkg.sv
// rtl/ascon_128a_pkg.sv - shared state encoding and frame constants for the ascon-128a stream loader
package ascon_128a_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int WORDS_IN         = 16;
    localparam int WORDS_OUT        = 8;
    localparam int CORE_LATENCY_MIN = 17;

endpackage

// File: rtl/ascon_128a_stream_loader_if.sv
// rtl/ascon_128a_stream_loader_if.sv - 32-bit valid/ready input and output streams of the loader
interface ascon_128a_stream_loader_if;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/ascon_word_serializer.sv
// rtl/ascon_word_serializer.sv - holds a 256-bit {T,C} block and emits it as 8x32 valid/ready words
module ascon_word_serializer
    import ascon_128a_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [255:0] load_data,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done
);

    logic [255:0] buf_q;
    logic [2:0]   word_q;
    logic         valid_q;
    logic         last_word;

    assign last_word = (word_q == 3'(WORDS_OUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            buf_q   <= load_data;
            word_q  <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            if (last_word) begin
                word_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                word_q  <= word_q + 3'd1;
            end
        end
    end

    // The word index only moves on a handshake, so data holds under back-pressure.
    assign out_data  = buf_q[{word_q, 5'b0} +: 32];
    assign out_valid = valid_q;
    assign done      = valid_q & out_ready & last_word;

endmodule

// File: rtl/ascon_128a_stream_loader.sv
// rtl/ascon_128a_stream_loader.sv - loads SK/N/A/P from a word stream, times the core, streams C/T back
module ascon_128a_stream_loader
    import ascon_128a_pkg::*;
#(
    parameter int CORE_LATENCY = 17
) (
    input  logic                         clk,
    input  logic                         reset,
    ascon_128a_stream_loader_if.slave    s,
    output logic                         busy,
    output logic                         core_reset,
    output logic [127:0]                 core_sk,
    output logic [127:0]                 core_n,
    output logic [127:0]                 core_a,
    output logic [127:0]                 core_p,
    input  logic [127:0]                 core_c,
    input  logic [127:0]                 core_t
);

    state_t      state_q, state_d;
    logic [3:0]  in_word_q;
    logic [4:0]  lat_cnt_q;
    logic        in_hs;
    logic        capture;
    logic        drain_done;

    assign s.in_ready = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_LOAD);
    assign in_hs      = s.in_valid & (state_q == ST_LOAD);
    assign capture    = (state_q == ST_RUN) && (lat_cnt_q == 5'(CORE_LATENCY));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (in_hs && (in_word_q == 4'(WORDS_IN - 1))) state_d = ST_RUN;
            ST_RUN:   if (capture) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_word_q  <= '0;
            lat_cnt_q  <= '0;
            core_reset <= 1'b1;
            core_sk    <= '0;
            core_n     <= '0;
            core_a     <= '0;
            core_p     <= '0;
        end else begin
            // The core runs only while the registered reset is low, i.e. exactly the RUN cycles.
            core_reset <= (state_d != ST_RUN);
            lat_cnt_q  <= (state_q == ST_RUN && !capture) ? lat_cnt_q + 5'd1 : 5'd0;
            if (in_hs) begin
                in_word_q <= in_word_q + 4'd1;
                case (in_word_q[3:2])
                    2'd0:    core_sk[{in_word_q[1:0], 5'b0} +: 32] <= s.in_data;
                    2'd1:    core_n [{in_word_q[1:0], 5'b0} +: 32] <= s.in_data;
                    2'd2:    core_a [{in_word_q[1:0], 5'b0} +: 32] <= s.in_data;
                    default: core_p [{in_word_q[1:0], 5'b0} +: 32] <= s.in_data;
                endcase
            end
        end
    end

    ascon_word_serializer u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (capture),
        .load_data ({core_t, core_c}),
        .out_data  (s.out_data),
        .out_valid (s.out_valid),
        .out_ready (s.out_ready),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_ascon_128a_stream_loader.sv
// tb/tb_ascon_128a_stream_loader.sv - directed self-checking bench for the ascon-128a stream loader
module tb_ascon_128a_stream_loader;

    localparam int CL = 17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ascon_128a_stream_loader_if bus ();

    logic         busy, core_reset;
    logic [127:0] core_sk, core_n, core_a, core_p, core_c, core_t;
    logic [31:0]  low_cnt;

    ascon_128a_stream_loader #(.CORE_LATENCY(CL)) dut (
        .clk        (clk),
        .reset      (reset),
        .s          (bus),
        .busy       (busy),
        .core_reset (core_reset),
        .core_sk    (core_sk),
        .core_n     (core_n),
        .core_a     (core_a),
        .core_p     (core_p),
        .core_c     (core_c),
        .core_t     (core_t)
    );

    // Core stand-in: outputs depend on how long it has run, so a mistimed capture shows up.
    always @(posedge clk) begin
        if (core_reset) low_cnt <= 32'd0;
        else            low_cnt <= low_cnt + 32'd1;
    end
    assign core_c = core_sk ^ core_n ^ {96'b0, low_cnt};
    assign core_t = core_a ^ core_p ^ {low_cnt, 96'b0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    logic [127:0] f_sk, f_n, f_a, f_p;

    function automatic logic [31:0] frame_word(input int k);
        logic [127:0] fld;
        case (k / 4)
            0:       fld = f_sk;
            1:       fld = f_n;
            2:       fld = f_a;
            default: fld = f_p;
        endcase
        return fld[32*(k%4) +: 32];
    endfunction

    task automatic push_frame(input bit gappy);
        int n;
        for (int k = 0; k < 16; k++) begin
            if (gappy) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_data  = frame_word(k);
            bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) check("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_latency(output int lat, output int low);
        lat = 1;
        low = 0;
        while (!bus.out_valid && lat < 100) begin
            if (!core_reset) low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic drain(input bit bp);
        logic [255:0] ct;
        logic [31:0]  exp;
        int n;
        ct = {f_a ^ f_p ^ {32'(CL), 96'b0}, f_sk ^ f_n ^ {96'b0, 32'(CL)}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = ct[32*i +: 32];
            n = 0;
            while (!bus.out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (bp && i == 3) begin
                bus.out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    check($sformatf("bp_hold%0d", j), bus.out_data, exp);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
            check($sformatf("out_word%0d", i), {bus.out_valid, bus.out_data}, {1'b1, exp});
            if (i == 7) bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("post_drain_valid", bus.out_valid, 0);
        check("post_drain_busy", busy, 0);
        check("post_drain_ready", bus.in_ready, 1);
    endtask

    int lat, low;
    bit seen;

    initial begin
        bus.in_data   = 32'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_out_data", bus.out_data, 0);
        check("rst_core_sk", core_sk, 0);

        // Frame 1: word mapping, back-to-back
        f_sk = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        f_n  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
        f_a  = '0;
        f_p  = '0;
        push_frame(1'b0);
        check("map_sk", core_sk, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check("map_n",  core_n,  128'h1F1E1D1C_1B1A1918_17161514_13121110);
        check("map_a",  core_a,  0);
        check("map_p",  core_p,  0);
        check("run_busy", busy, 1);
        check("run_in_ready", bus.in_ready, 0);
        wait_latency(lat, low);
        check("latency", lat, CL + 2);
        check("core_reset_low", low, CL + 1);
        drain(1'b0);

        // Frame 2: gappy input plus back-pressure on word 3
        push_frame(1'b1);
        check("gappy_sk", core_sk, f_sk);
        check("gappy_n", core_n, f_n);
        wait_latency(lat, low);
        check("gappy_latency", lat, CL + 2);
        drain(1'b1);

        // Frame 3: reset while running at lat_cnt=5
        push_frame(1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_core_reset", core_reset, 1);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_busy", busy, 0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("mid_rst_no_output", seen, 0);

        // Frame 4: fresh values, input held high with junk during RUN/DRAIN
        f_sk = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        f_n  = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
        f_a  = 128'h11112222_33334444_55556666_77778888;
        f_p  = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;
        push_frame(1'b0);
        bus.in_data  = 32'hDEADBEEF;
        bus.in_valid = 1'b1;
        wait_latency(lat, low);
        check("ign_latency", lat, CL + 2);
        drain(1'b0);
        check("ign_sk", core_sk, f_sk);
        check("ign_n", core_n, f_n);
        check("ign_a", core_a, f_a);
        check("ign_p", core_p, f_p);

        // Frame 5: next frame's word 0 must land in SK[31:0]
        f_sk = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
        f_n  = 128'h00000001_00000002_00000003_00000004;
        f_a  = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
        f_p  = 128'h0000FFFF_FFFF0000_0F0F0F0F_F0F0F0F0;
        push_frame(1'b0);
        check("next_sk_word0", core_sk[31:0], 32'h9ABCDEF0);
        check("next_sk", core_sk, f_sk);
        check("next_p", core_p, f_p);
        wait_latency(lat, low);
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
